turn_controller: RTL

Game sequencer for the tic-tac-toe board. Accepts debounced move requests from the player (and, in player-vs-computer mode, cell choices from the computer move generator). It validates each move against its own occupancy shadow and issues single-cycle write strobes with cell codes to `memory_unit` on `pl_inp`/`comp_inp`. It also detects win and draw and reports game status to the display logic.

---
 rtl/turn_controller.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/turn_controller.sv
// turn_controller: tic-tac-toe game sequencer.
// Validates X/O moves against an internal occupancy shadow, issues single-cycle
// write strobes with cell codes to the board memory, serves the computer move
// generator in player-vs-computer mode (with timeout fallback), and reports
// win/draw status. All outputs are registered.
//
// Ports:
//   clk, reset               - clock, asynchronous active-high reset
//   new_game                 - one-cycle pulse, restart game (highest priority)
//   gamemode_switch          - 0 = PvP, 1 = PvC; latched only at game start
//   btn_move, sel_cell[3:0]  - player move request and selected cell (0-8)
//   comp_move_valid, comp_cell[3:0] - computer move and its cell
//   pl_inp[3:0], wr_pl       - X cell code and its write strobe
//   comp_inp[3:0], wr_comp   - O cell code and its write strobe
//   comp_req                 - level request to the computer move generator
//   turn                     - 0 = X to move, 1 = O to move
//   status[1:0]              - 00 playing, 01 X wins, 10 O wins, 11 draw
//   err                      - one-cycle pulse on a rejected move
//   board_x[8:0], board_o[8:0] - occupancy shadow, bit n = cell n
module turn_controller #(
    parameter int unsigned COMP_TIMEOUT = 1000,
    parameter int unsigned TO_W         = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       new_game,
    input  logic       gamemode_switch,
    input  logic       btn_move,
    input  logic [3:0] sel_cell,
    input  logic       comp_move_valid,
    input  logic [3:0] comp_cell,
    output logic [3:0] pl_inp,
    output logic [3:0] comp_inp,
    output logic       wr_pl,
    output logic       wr_comp,
    output logic       comp_req,
    output logic       turn,
    output logic [1:0] status,
    output logic       err,
    output logic [8:0] board_x,
    output logic [8:0] board_o
);

    typedef enum logic [2:0] {
        StInit,
        StX,
        StO,
        StCreq,
        StCheck,
        StOver
    } state_e;

    localparam logic [TO_W-1:0] TimeoutVal = TO_W'(COMP_TIMEOUT);

    state_e          state_q, state_d;
    logic            mode_q, mode_d;
    logic [TO_W-1:0] cnt_q, cnt_d;

    logic [3:0] pl_inp_d, comp_inp_d;
    logic       wr_pl_d, wr_comp_d, comp_req_d, turn_d, err_d;
    logic [1:0] status_d;
    logic [8:0] board_x_d, board_o_d;

    logic [8:0] occ;
    logic [8:0] sel_mask, comp_mask, low_mask;
    logic       sel_ok, comp_ok;
    logic [3:0] low_free;
    logic       win_x, win_o;

    function automatic logic has_line(input logic [8:0] b);
        return (b[0] & b[1] & b[2]) | (b[3] & b[4] & b[5]) | (b[6] & b[7] & b[8]) |
               (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
               (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
    endfunction

    assign occ       = board_x | board_o;
    // Out-of-range cell codes map to an empty mask and are therefore illegal.
    assign sel_mask  = (sel_cell <= 4'd8) ? (9'd1 << sel_cell) : 9'd0;
    assign comp_mask = (comp_cell <= 4'd8) ? (9'd1 << comp_cell) : 9'd0;
    assign sel_ok    = (|sel_mask) && ~(|(sel_mask & occ));
    assign comp_ok   = (|comp_mask) && ~(|(comp_mask & occ));
    assign low_mask  = 9'd1 << low_free;
    assign win_x     = has_line(board_x);
    assign win_o     = has_line(board_o);

    // Lowest-index free cell; scanning downward lets the lowest index win.
    always_comb begin
        low_free = 4'd0;
        for (int i = 8; i >= 0; i--) begin
            if (!occ[i]) low_free = 4'(i);
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        pl_inp_d   = pl_inp;
        comp_inp_d = comp_inp;
        wr_pl_d    = 1'b0;
        wr_comp_d  = 1'b0;
        err_d      = 1'b0;
        comp_req_d = comp_req;
        turn_d     = turn;
        status_d   = status;
        board_x_d  = board_x;
        board_o_d  = board_o;

        if (new_game) begin
            state_d    = StInit;
            status_d   = 2'b00;
            turn_d     = 1'b0;
            comp_req_d = 1'b0;
        end else begin
            case (state_q)
                StInit: begin
                    mode_d    = gamemode_switch;
                    board_x_d = 9'd0;
                    board_o_d = 9'd0;
                    state_d   = StX;
                end
                StX: begin
                    if (btn_move) begin
                        if (sel_ok) begin
                            board_x_d = board_x | sel_mask;
                            pl_inp_d  = sel_cell;
                            wr_pl_d   = 1'b1;
                            state_d   = StCheck;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                StO: begin
                    if (btn_move) begin
                        if (sel_ok) begin
                            board_o_d  = board_o | sel_mask;
                            comp_inp_d = sel_cell;
                            wr_comp_d  = 1'b1;
                            state_d    = StCheck;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                StCreq: begin
                    cnt_d = cnt_q + 1'b1;
                    if (comp_move_valid && comp_ok) begin
                        board_o_d  = board_o | comp_mask;
                        comp_inp_d = comp_cell;
                        wr_comp_d  = 1'b1;
                        comp_req_d = 1'b0;
                        state_d    = StCheck;
                    end else if (cnt_q == TimeoutVal) begin
                        // Counter starts at zero in the cycle comp_req rises, so the
                        // fallback strobe lands COMP_TIMEOUT+1 cycles after the request.
                        board_o_d  = board_o | low_mask;
                        comp_inp_d = low_free;
                        wr_comp_d  = 1'b1;
                        comp_req_d = 1'b0;
                        state_d    = StCheck;
                    end else if (comp_move_valid) begin
                        err_d = 1'b1;
                    end
                end
                StCheck: begin
                    if (win_x) begin
                        status_d = 2'b01;
                        state_d  = StOver;
                    end else if (win_o) begin
                        status_d = 2'b10;
                        state_d  = StOver;
                    end else if (&occ) begin
                        status_d = 2'b11;
                        state_d  = StOver;
                    end else begin
                        // turn still names the side that just moved
                        turn_d = ~turn;
                        if (turn) begin
                            state_d = StX;
                        end else if (mode_q) begin
                            state_d    = StCreq;
                            comp_req_d = 1'b1;
                            cnt_d      = '0;
                        end else begin
                            state_d = StO;
                        end
                    end
                end
                StOver: ;
                default: state_d = StInit;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StInit;
            mode_q   <= 1'b0;
            cnt_q    <= '0;
            pl_inp   <= 4'd0;
            comp_inp <= 4'd0;
            wr_pl    <= 1'b0;
            wr_comp  <= 1'b0;
            comp_req <= 1'b0;
            turn     <= 1'b0;
            status   <= 2'b00;
            err      <= 1'b0;
            board_x  <= 9'd0;
            board_o  <= 9'd0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            pl_inp   <= pl_inp_d;
            comp_inp <= comp_inp_d;
            wr_pl    <= wr_pl_d;
            wr_comp  <= wr_comp_d;
            comp_req <= comp_req_d;
            turn     <= turn_d;
            status   <= status_d;
            err      <= err_d;
            board_x  <= board_x_d;
            board_o  <= board_o_d;
        end
    end

endmodule
